// File: rtl/vram_pkg.sv
// Shared widths and enumerations for the video SRAM arbiter.
package vram_pkg;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {IDLE, RD, WR1, WR2, TURN} state_t;
  typedef enum logic [1:0] {NONE, VID, CPU} tag_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// Requester and SRAM bus signals of the video SRAM arbiter; slave is the arbiter side.
interface vram_arbiter_if;
  import vram_pkg::*;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_adr;
  logic              vid_gnt;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_dat;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_wdat;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdat;

  logic              v_we;
  logic              v_oe_sram;
  logic              v_oe_pin;
  logic [ADDR_W-1:0] v_adr;
  logic [DATA_W-1:0] v_dat_o;
  logic [DATA_W-1:0] v_dat_i;

  modport slave (
    input  vid_req, vid_adr, cpu_req, cpu_we, cpu_adr, cpu_wdat, v_dat_i,
    output vid_gnt, vid_valid, vid_dat, cpu_ack, cpu_rdat,
           v_we, v_oe_sram, v_oe_pin, v_adr, v_dat_o
  );

  modport master (
    output vid_req, vid_adr, cpu_req, cpu_we, cpu_adr, cpu_wdat, v_dat_i,
    input  vid_gnt, vid_valid, vid_dat, cpu_ack, cpu_rdat,
           v_we, v_oe_sram, v_oe_pin, v_adr, v_dat_o
  );
endinterface

// File: rtl/vram_rd_tag_pipe.sv
// Tracks the owner of each in-flight SRAM read; the head tag lines up with v_dat_i.
module vram_rd_tag_pipe
  import vram_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk_vga,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_head
);

  tag_t tag_p [RD_LAT];

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_p[i] <= NONE;
    end else begin
      tag_p[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  assign tag_head = tag_p[RD_LAT-1];

endmodule

// File: rtl/vram_arbiter.sv
// Video SRAM arbiter: VDP reads have priority, the CPU is forced a slot after
// CPU_MAX_WAIT lost cycles. Reads pipeline one per cycle; writes run WR1/WR2/TURN.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int RD_LAT       = 2,
  parameter int CPU_MAX_WAIT = 8
) (
  input logic           clk_vga,
  input logic           rst,
  vram_arbiter_if.slave bus
);

  localparam int              CNT_W   = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_MAX_WAIT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             cpu_busy;
  logic             arb_ok, cpu_pend, cpu_force;
  logic             vid_acc, cpu_acc, cpu_rd_acc, cpu_wr_acc;
  tag_t             tag_in, tag_head;

  always_ff @(posedge clk_vga) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, RD, TURN: begin
        if (cpu_wr_acc)                 state_nxt = WR1;
        else if (vid_acc || cpu_rd_acc) state_nxt = RD;
        else                            state_nxt = IDLE;
      end
      WR1:     state_nxt = WR2;
      WR2:     state_nxt = TURN;
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration only in bus-free states; the CPU is ignored while its op is outstanding.
  always_comb begin
    arb_ok      = !rst && (state == IDLE || state == RD || state == TURN);
    cpu_pend    = bus.cpu_req && !cpu_busy;
    cpu_force   = cpu_pend && (starve_cnt == CNT_MAX);
    bus.vid_gnt = arb_ok && !cpu_force;
    vid_acc     = bus.vid_gnt && bus.vid_req;
    cpu_acc     = arb_ok && cpu_pend && !vid_acc;
    cpu_rd_acc  = cpu_acc && !bus.cpu_we;
    cpu_wr_acc  = cpu_acc && bus.cpu_we;
    tag_in      = vid_acc ? VID : (cpu_rd_acc ? CPU : NONE);
  end

  vram_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk_vga  (clk_vga),
    .rst      (rst),
    .tag_in   (tag_in),
    .tag_head (tag_head)
  );

  // Bus issue stage (C+1) and return stage (C+1+RD_LAT).
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      starve_cnt    <= '0;
      cpu_busy      <= 1'b0;
      bus.v_we      <= 1'b0;
      bus.v_oe_sram <= 1'b0;
      bus.v_oe_pin  <= 1'b0;
      bus.v_adr     <= '0;
      bus.v_dat_o   <= '0;
      bus.vid_valid <= 1'b0;
      bus.vid_dat   <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdat  <= '0;
    end else begin
      if (cpu_acc)                              starve_cnt <= '0;
      else if (cpu_pend && starve_cnt < CNT_MAX) starve_cnt <= starve_cnt + 1'b1;

      if (cpu_acc)          cpu_busy <= 1'b1;
      else if (bus.cpu_ack) cpu_busy <= 1'b0;

      bus.v_oe_sram <= vid_acc || cpu_rd_acc;
      bus.v_we      <= (state_nxt == WR1) || (state_nxt == WR2);
      bus.v_oe_pin  <= (state_nxt == WR1) || (state_nxt == WR2);
      if (vid_acc)      bus.v_adr   <= bus.vid_adr;
      else if (cpu_acc) bus.v_adr   <= bus.cpu_adr;
      if (cpu_wr_acc)   bus.v_dat_o <= bus.cpu_wdat;

      bus.vid_valid <= (tag_head == VID);
      if (tag_head == VID) bus.vid_dat <= bus.v_dat_i;
      bus.cpu_ack   <= (tag_head == CPU) || (state == WR2);
      if (tag_head == CPU) bus.cpu_rdat <= bus.v_dat_i;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: SRAM board model, request-level scoreboard and scenario tasks.
module tb_vram_arbiter;
  import vram_pkg::*;

  logic clk_vga = 1'b0;
  logic rst;
  always #5 clk_vga = ~clk_vga;

  vram_arbiter_if bus ();

  vram_arbiter #(.RD_LAT(2), .CPU_MAX_WAIT(8)) dut (
    .clk_vga (clk_vga),
    .rst     (rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct { int cyc; logic [ADDR_W-1:0] adr; logic [DATA_W-1:0] dat; } vexp_t;
  typedef struct { int cyc; logic [DATA_W-1:0] dat; } vlog_t;
  vexp_t vq[$];
  vlog_t vlog[$];

  logic [DATA_W-1:0] mem_w [int];
  logic [DATA_W-1:0] ref_w [int];
  logic              we_d = 1'b0;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return 16'hA000 + a[15:0];
  endfunction

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    if (mem_w.exists(int'(a))) return mem_w[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    if (ref_w.exists(int'(a))) return ref_w[int'(a)];
    return init_val(a);
  endfunction

  initial forever begin
    @(posedge clk_vga);
    cyc++;
  end

  // SRAM board: one data register on reads, write data committed on the second strobe cycle.
  initial forever begin
    @(posedge clk_vga);
    if (bus.v_we && we_d) mem_w[int'(bus.v_adr)] = bus.v_dat_o;
    bus.v_dat_i <= bus.v_oe_sram ? mem_rd(bus.v_adr) : '0;
    we_d        <= bus.v_we;
  end

  // Request-level reference: reads return memory contents as of their acceptance.
  initial begin
    vexp_t e;
    vlog_t l;
    forever begin
      @(negedge clk_vga);
      if (rst) begin
        vq.delete();
      end else begin
        checks++;
        if ((bus.v_we && bus.v_oe_sram) || (bus.v_oe_pin !== bus.v_we)) begin
          errors++;
          $display("FAIL bus_invariant cyc=%0d got we=%b oe_sram=%b oe_pin=%b, need not(we&oe_sram) and oe_pin==we",
                   cyc, bus.v_we, bus.v_oe_sram, bus.v_oe_pin);
        end
        if (bus.cpu_ack) begin
          checks++;
          if (!bus.cpu_req) begin
            errors++;
            $display("FAIL cpu_ack_spurious cyc=%0d got ack=1 with no request, need 0", cyc);
          end else if (bus.cpu_we) begin
            ref_w[int'(bus.cpu_adr)] = bus.cpu_wdat;
          end else if (bus.cpu_rdat !== ref_rd(bus.cpu_adr)) begin
            errors++;
            $display("FAIL cpu_rdat cyc=%0d adr=%h got %h need %h", cyc, bus.cpu_adr, bus.cpu_rdat, ref_rd(bus.cpu_adr));
          end
        end
        if (bus.vid_valid) begin
          l.cyc = cyc;
          l.dat = bus.vid_dat;
          vlog.push_back(l);
          checks++;
          if (vq.size() == 0) begin
            errors++;
            $display("FAIL vid_valid_unexpected cyc=%0d got valid dat=%h, need no valid", cyc, bus.vid_dat);
          end else begin
            e = vq.pop_front();
            if (bus.vid_dat !== e.dat || cyc != e.cyc) begin
              errors++;
              $display("FAIL vid_return adr=%h got dat=%h cyc=%0d need dat=%h cyc=%0d",
                       e.adr, bus.vid_dat, cyc, e.dat, e.cyc);
            end
          end
        end
        if (bus.vid_req && bus.vid_gnt) begin
          e.cyc = cyc + 3;
          e.adr = bus.vid_adr;
          e.dat = ref_rd(bus.vid_adr);
          vq.push_back(e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got cyc=%0d need completion", cyc);
    $fatal(1, "timeout");
  end

  task automatic vid_stream(input int n, input bit rnd, input int base, input bit gaps);
    int  sent  = 0;
    int  guard = 0;
    bit  acc;
    @(posedge clk_vga); #1;
    bus.vid_req = 1'b1;
    bus.vid_adr = rnd ? ADDR_W'($urandom_range(127, 0)) : ADDR_W'(base);
    while (sent < n && guard < 4000) begin
      guard++;
      @(negedge clk_vga);
      acc = bus.vid_req && bus.vid_gnt;
      @(posedge clk_vga); #1;
      if (acc) sent++;
      if (acc || !bus.vid_req) begin
        if (sent < n && (!gaps || $urandom_range(3, 0) != 0)) begin
          bus.vid_req = 1'b1;
          bus.vid_adr = rnd ? ADDR_W'($urandom_range(127, 0)) : ADDR_W'(base + sent);
        end else begin
          bus.vid_req = 1'b0;
        end
      end
    end
    bus.vid_req = 1'b0;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL vid_stream_timeout got %0d accepted need %0d", sent, n);
    end
  endtask

  task automatic cpu_op(input bit we, input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] wdat);
    int n = 0;
    bus.cpu_we   = we;
    bus.cpu_adr  = adr;
    bus.cpu_wdat = wdat;
    bus.cpu_req  = 1'b1;
    do begin
      @(negedge clk_vga);
      n++;
    end while (!bus.cpu_ack && n < 200);
    checks++;
    if (!bus.cpu_ack) begin
      errors++;
      $display("FAIL cpu_op_timeout adr=%h got no ack need ack within 200 cycles", adr);
    end
    @(posedge clk_vga); #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    int nv = 0;
    repeat (2) @(posedge clk_vga);
    #1;
    bus.vid_req = 1'b1;
    bus.vid_adr = 17'h00005;
    @(negedge clk_vga);
    checks++;
    if (bus.vid_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt got %b need 0", bus.vid_gnt);
    end
    @(posedge clk_vga); #1;
    rst = 1'b0;
    bus.vid_req = 1'b0;
    @(negedge clk_vga);
    checks++;
    if ({bus.v_we, bus.v_oe_sram, bus.v_oe_pin, bus.v_adr, bus.v_dat_o, bus.vid_valid,
         bus.vid_dat, bus.cpu_ack, bus.cpu_rdat} !== '0) begin
      errors++; $display("FAIL reset_outputs got adr=%h oe=%b we=%b need all 0", bus.v_adr, bus.v_oe_sram, bus.v_we);
    end
    @(posedge clk_vga); #1;
    bus.vid_req = 1'b1;
    bus.vid_adr = 17'h00010;
    @(negedge clk_vga);
    checks++;
    if (bus.vid_gnt !== 1'b1) begin
      errors++; $display("FAIL midread_accept got gnt=%b need 1", bus.vid_gnt);
    end
    @(posedge clk_vga); #1;
    bus.vid_req = 1'b0;
    rst = 1'b1;
    @(negedge clk_vga);
    checks++;
    if (bus.v_oe_sram !== 1'b1 || bus.v_adr !== 17'h00010) begin
      errors++; $display("FAIL midread_issue got oe=%b adr=%h need 1 00010", bus.v_oe_sram, bus.v_adr);
    end
    @(posedge clk_vga); #1;
    rst = 1'b0;
    @(negedge clk_vga);
    checks++;
    if ({bus.v_we, bus.v_oe_sram, bus.v_oe_pin, bus.v_adr, bus.v_dat_o, bus.vid_valid, bus.cpu_ack} !== '0) begin
      errors++; $display("FAIL midread_outputs got adr=%h oe=%b valid=%b need all 0", bus.v_adr, bus.v_oe_sram, bus.vid_valid);
    end
    repeat (6) begin
      @(negedge clk_vga);
      if (bus.vid_valid) nv++;
    end
    checks++;
    if (nv != 0) begin
      errors++; $display("FAIL midread_no_valid got %0d pulses need 0", nv);
    end
  endtask

  task automatic test_video_stream();
    int c0;
    vlog.delete();
    @(posedge clk_vga); #1;
    c0 = cyc;
    bus.vid_req = 1'b1;
    bus.vid_adr = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_vga);
      checks++;
      if (bus.vid_gnt !== 1'b1) begin
        errors++; $display("FAIL stream_gnt k=%0d got %b need 1", k, bus.vid_gnt);
      end
      @(posedge clk_vga); #1;
      if (k < 7) bus.vid_adr = ADDR_W'(k + 1);
      else       bus.vid_req = 1'b0;
    end
    repeat (6) @(negedge clk_vga);
    checks++;
    if (vlog.size() != 8) begin
      errors++; $display("FAIL stream_count got %0d need 8", vlog.size());
    end
    for (int k = 0; k < 8 && k < vlog.size(); k++) begin
      checks++;
      if (vlog[k].cyc != c0 + 3 + k || vlog[k].dat !== 16'(16'hA000 + k)) begin
        errors++;
        $display("FAIL stream_data k=%0d got cyc=%0d dat=%h need cyc=%0d dat=%h",
                 k, vlog[k].cyc, vlog[k].dat, c0 + 3 + k, 16'(16'hA000 + k));
      end
    end
  endtask

  task automatic test_cpu_write_read();
    bit exp_we, exp_ack;
    @(posedge clk_vga); #1;
    bus.cpu_we = 1'b1; bus.cpu_adr = 17'h1FFFF; bus.cpu_wdat = 16'hBEEF; bus.cpu_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_vga);
      exp_we  = (k == 1 || k == 2);
      exp_ack = (k == 3);
      checks++;
      if (bus.v_we !== exp_we || bus.v_oe_pin !== exp_we || bus.cpu_ack !== exp_ack) begin
        errors++;
        $display("FAIL wr_strobe k=%0d got we=%b pin=%b ack=%b need we=%b pin=%b ack=%b",
                 k, bus.v_we, bus.v_oe_pin, bus.cpu_ack, exp_we, exp_we, exp_ack);
      end
      if (exp_we) begin
        checks++;
        if (bus.v_adr !== 17'h1FFFF || bus.v_dat_o !== 16'hBEEF || bus.v_oe_sram !== 1'b0) begin
          errors++;
          $display("FAIL wr_bus k=%0d got adr=%h dat=%h oe=%b need 1ffff beef 0", k, bus.v_adr, bus.v_dat_o, bus.v_oe_sram);
        end
      end
      @(posedge clk_vga); #1;
      if (k == 3) bus.cpu_req = 1'b0;
    end
    checks++;
    if (mem_rd(17'h1FFFF) !== 16'hBEEF) begin
      errors++; $display("FAIL wr_commit got %h need beef", mem_rd(17'h1FFFF));
    end
    bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_vga);
      if (k == 1) begin
        checks++;
        if (bus.v_oe_sram !== 1'b1 || bus.v_adr !== 17'h1FFFF || bus.v_we !== 1'b0) begin
          errors++; $display("FAIL rd_issue got oe=%b adr=%h we=%b need 1 1ffff 0", bus.v_oe_sram, bus.v_adr, bus.v_we);
        end
      end
      checks++;
      if (bus.cpu_ack !== (k == 3) || (k == 3 && bus.cpu_rdat !== 16'hBEEF)) begin
        errors++; $display("FAIL rd_ack k=%0d got ack=%b rdat=%h need ack=%b rdat=beef", k, bus.cpu_ack, bus.cpu_rdat, k == 3);
      end
      @(posedge clk_vga); #1;
      if (k == 3) bus.cpu_req = 1'b0;
    end
  endtask

  task automatic test_starvation();
    bit g;
    @(posedge clk_vga); #1;
    bus.vid_req = 1'b1; bus.vid_adr = 17'h00040;
    bus.cpu_we = 1'b0; bus.cpu_adr = 17'h00100; bus.cpu_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_vga);
      g = bus.vid_gnt;
      checks++;
      if (g !== (k != 8)) begin
        errors++; $display("FAIL starve_gnt k=%0d got %b need %b", k, g, k != 8);
      end
      if (k == 9) begin
        checks++;
        if (bus.v_adr !== 17'h00100 || bus.v_oe_sram !== 1'b1) begin
          errors++; $display("FAIL starve_cpu_issue got adr=%h oe=%b need 00100 1", bus.v_adr, bus.v_oe_sram);
        end
      end
      if (k == 11) begin
        checks++;
        if (bus.cpu_ack !== 1'b1) begin
          errors++; $display("FAIL starve_ack got %b need 1", bus.cpu_ack);
        end
      end
      @(posedge clk_vga); #1;
      if (g) bus.vid_adr = bus.vid_adr + 1'b1;
      if (k == 11) bus.cpu_req = 1'b0;
    end
    bus.vid_req = 1'b0;
    repeat (4) @(posedge clk_vga);
  endtask

  task automatic test_mixed();
    fork
      vid_stream(4, 1'b0, 32'h20, 1'b0);
      begin
        @(posedge clk_vga); #1;
        cpu_op(1'b1, 17'h00021, 16'h1234);
      end
    join
    vid_stream(2, 1'b0, 32'h20, 1'b0);
    repeat (6) @(negedge clk_vga);
    checks++;
    if (vq.size() != 0) begin
      errors++; $display("FAIL mixed_drain got %0d pending need 0", vq.size());
    end
  endtask

  task automatic test_turnaround();
    int  first_oe = -1;
    bit  g;
    @(posedge clk_vga); #1;
    bus.cpu_we = 1'b1; bus.cpu_adr = 17'h00030; bus.cpu_wdat = 16'h5A5A; bus.cpu_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_vga);
      g = bus.vid_req && bus.vid_gnt;
      if (k == 1 || k == 2) begin
        checks++;
        if (bus.vid_gnt !== 1'b0) begin
          errors++; $display("FAIL turn_gnt_in_write k=%0d got %b need 0", k, bus.vid_gnt);
        end
      end
      if (bus.v_oe_sram && first_oe < 0) first_oe = k;
      @(posedge clk_vga); #1;
      if (k == 0) begin bus.vid_req = 1'b1; bus.vid_adr = 17'h00030; end
      if (g) bus.vid_req = 1'b0;
      if (k == 3) bus.cpu_req = 1'b0;
    end
    checks++;
    if (first_oe != 4) begin
      errors++; $display("FAIL turn_first_oe got C+%0d need C+4", first_oe);
    end
  endtask

  task automatic test_random();
    fork
      vid_stream(60, 1'b1, 0, 1'b1);
      begin
        @(posedge clk_vga); #1;
        repeat (15) begin
          cpu_op(1'($urandom_range(1, 0)), ADDR_W'($urandom_range(127, 0)), DATA_W'($urandom));
          repeat ($urandom_range(5, 0)) begin @(posedge clk_vga); #1; end
        end
      end
    join
    repeat (8) @(negedge clk_vga);
    checks++;
    if (vq.size() != 0) begin
      errors++; $display("FAIL random_drain got %0d pending need 0", vq.size());
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.vid_req  = 1'b0;
    bus.vid_adr  = '0;
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_adr  = '0;
    bus.cpu_wdat = '0;
    test_reset();
    test_video_stream();
    test_cpu_write_read();
    test_starvation();
    test_mixed();
    test_turnaround();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
